// File: rtl/energy_uart_tx.sv
// Sample FIFO feeding an 8N1 UART transmitter for the energy-logger link.
// Define ENERGY_UART_PARITY_EN to append an even-parity bit before the stop bit.
module energy_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic       sample_ready,
  input  logic       ovf_clr,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef ENERGY_UART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  state_t        state_reg;
  logic [CW-1:0] baud_cnt_reg;
  logic [2:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic          tx_reg;
  logic          busy_reg;
  logic          overflow_reg;
`ifdef ENERGY_UART_PARITY_EN
  logic          parity_reg;
`endif

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty   = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign push         = sample_valid && !fifo_full;
  assign pop          = (state_reg == S_IDLE) && !fifo_empty;
  assign sample_ready = !fifo_full;
  assign tx           = tx_reg;
  assign busy         = busy_reg;
  assign overflow     = overflow_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= sample_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      // A new drop outranks a simultaneous clear.
      if (sample_valid && fifo_full) overflow_reg <= 1'b1;
      else if (ovf_clr)              overflow_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
`ifdef ENERGY_UART_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          tx_reg       <= 1'b1;
          busy_reg     <= 1'b0;
          baud_cnt_reg <= '0;
          if (pop) begin
            shift_reg <= mem[rd_ptr_reg[AW-1:0]];
`ifdef ENERGY_UART_PARITY_EN
            parity_reg <= ^mem[rd_ptr_reg[AW-1:0]];
`endif
            tx_reg    <= 1'b0;
            busy_reg  <= 1'b1;
            state_reg <= S_START;
          end
        end
        S_START: begin
          if (baud_cnt_reg == BAUD_LAST) begin
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            tx_reg       <= shift_reg[0];
            shift_reg    <= {1'b0, shift_reg[7:1]};
            state_reg    <= S_DATA;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + CW'(1);
          end
        end
        S_DATA: begin
          if (baud_cnt_reg == BAUD_LAST) begin
            baud_cnt_reg <= '0;
            if (bit_cnt_reg == 3'd7) begin
`ifdef ENERGY_UART_PARITY_EN
              tx_reg    <= parity_reg;
              state_reg <= S_PARITY;
`else
              tx_reg    <= 1'b1;
              state_reg <= S_STOP;
`endif
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              tx_reg      <= shift_reg[0];
              shift_reg   <= {1'b0, shift_reg[7:1]};
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + CW'(1);
          end
        end
`ifdef ENERGY_UART_PARITY_EN
        S_PARITY: begin
          if (baud_cnt_reg == BAUD_LAST) begin
            baud_cnt_reg <= '0;
            tx_reg       <= 1'b1;
            state_reg    <= S_STOP;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + CW'(1);
          end
        end
`endif
        S_STOP: begin
          if (baud_cnt_reg == BAUD_LAST) begin
            baud_cnt_reg <= '0;
            busy_reg     <= 1'b0;
            state_reg    <= S_IDLE;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + CW'(1);
          end
        end
        default: begin
          state_reg <= S_IDLE;
          tx_reg    <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_energy_uart_tx.sv
// Directed + randomized bench for energy_uart_tx with a behavioural UART receiver.
// Honours ENERGY_UART_PARITY_EN to expect the parity bit and longer frames.
module tb_energy_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef ENERGY_UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       sample_ready;
  logic       ovf_clr;
  logic       tx;
  logic       busy;
  logic       overflow;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_data[$];
  logic       rx_start[$];
  logic       rx_stop[$];
  logic       rx_par[$];
  int         rx_cyc[$];

  energy_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .ovf_clr(ovf_clr), .tx(tx), .busy(busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // Receiver: samples each bit near its middle, timed from the falling start edge.
  initial begin : monitor
    logic [10:0] bits;
    logic        st;
    logic        aborted;
    int          s_cyc;
    forever begin
      @(negedge tx);
      aborted = 1'b0;
      @(negedge clk);
      s_cyc = cyc;
      if (!rst_n) aborted = 1'b1;
      repeat (CPB/2 - 1) begin
        @(negedge clk);
        if (!rst_n) aborted = 1'b1;
      end
      st = tx;
      bits = '0;
      for (int b = 0; b < NBITS - 1; b++) begin
        repeat (CPB) begin
          @(negedge clk);
          if (!rst_n) aborted = 1'b1;
        end
        bits[b] = tx;
      end
      if (!aborted) begin
        rx_data.push_back(bits[7:0]);
        rx_start.push_back(st);
        rx_stop.push_back(bits[NBITS-2]);
        rx_par.push_back(bits[8]);
        rx_cyc.push_back(s_cyc);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_push(input logic [7:0] d, input logic clr);
    sample_valid = 1'b1;
    sample_in    = d;
    ovf_clr      = clr;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    ovf_clr      = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 3000; i++) begin
      if (rx_data.size() >= n) break;
      @(posedge clk); #1;
    end
    chk("rx_count", rx_data.size(), n);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (!busy) break;
    end
    chk("idle", busy, 1'b0);
  endtask

  // Each received frame must match the next accepted sample in push order.
  task automatic check_frames();
    logic [7:0] e;
    chk("frames_pending", rx_data.size(), exp_q.size());
    while (exp_q.size() > 0 && rx_data.size() > 0) begin
      e = exp_q.pop_front();
      chk("rx_data", rx_data.pop_front(), e);
      chk("start_bit", rx_start.pop_front(), 1'b0);
      chk("stop_bit", rx_stop.pop_front(), 1'b1);
`ifdef ENERGY_UART_PARITY_EN
      chk("parity_bit", rx_par.pop_front(), ^e);
`else
      void'(rx_par.pop_front());
`endif
      void'(rx_cyc.pop_front());
    end
    exp_q.delete();
  endtask

  initial begin : stim
    int pc;
    int bc;
    int n;
    int lows;
    logic [7:0] d;

    rst_n = 1'b0; sample_valid = 1'b0; sample_in = '0; ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", sample_ready, 1'b1);
    chk("rst_ovf", overflow, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_tx", tx, 1'b1);
    chk("post_rst_busy", busy, 1'b0);

    // Single frame: latency and busy length.
    drive_push(8'h96, 1'b0);
    exp_q.push_back(8'h96);
    pc = cyc;
    chk("lat_accept_edge_tx", tx, 1'b1);
    @(posedge clk); #1;
    chk("lat_pop_edge_tx", tx, 1'b0);
    chk("lat_pop_edge_busy", busy, 1'b1);
    bc = 1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (busy) bc++;
      else break;
    end
    chk("busy_len", bc, FRAME);
    wait_rx(1);
    chk("start_offset", rx_cyc[0] - pc, 1);
    check_frames();
    wait_idle();

    // Back-to-back frames.
    drive_push(8'h96, 1'b0);
    drive_push(8'h2D, 1'b0);
    exp_q.push_back(8'h96);
    exp_q.push_back(8'h2D);
    wait_rx(2);
    if (rx_cyc.size() >= 2) chk("b2b_period", rx_cyc[1] - rx_cyc[0], FRAME + 1);
    check_frames();
    wait_idle();

    // Random bursts that never exceed FIFO plus shift register.
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(5, 1);
      for (int k = 0; k < n; k++) begin
        d = 8'($urandom);
        drive_push(d, 1'b0);
        exp_q.push_back(d);
      end
      if (n == 5) chk("burst_full_ready", sample_ready, 1'b0);
      chk("burst_no_ovf", overflow, 1'b0);
      wait_rx(n);
      check_frames();
      wait_idle();
    end

    // Overflow: five accepted, sixth dropped, then set beats clear.
    for (int k = 0; k < 5; k++) begin
      d = 8'($urandom);
      drive_push(d, 1'b0);
      exp_q.push_back(d);
    end
    chk("ovf_ready_after5", sample_ready, 1'b0);
    chk("ovf_before_drop", overflow, 1'b0);
    drive_push(8'hEE, 1'b0);
    chk("ovf_set", overflow, 1'b1);
    drive_push(8'hDD, 1'b1);
    chk("ovf_set_wins", overflow, 1'b1);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    chk("ovf_cleared", overflow, 1'b0);
    wait_rx(5);
    check_frames();
    wait_idle();
    repeat (2 * FRAME) @(posedge clk);
    #1;
    chk("no_extra_frame", rx_data.size(), 0);

    // Asynchronous reset in the middle of the data bits.
    drive_push(8'h00, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    chk("mid_data_tx_low", tx, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx", tx, 1'b1);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_ready", sample_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) lows++;
    end
    chk("no_low_after_rst", lows, 0);
    chk("aborted_not_received", rx_data.size(), 0);

`ifdef ENERGY_UART_PARITY_EN
    drive_push(8'h07, 1'b0);
    drive_push(8'h96, 1'b0);
    exp_q.push_back(8'h07);
    exp_q.push_back(8'h96);
    wait_rx(2);
    if (rx_par.size() >= 2) begin
      chk("parity_07", rx_par[0], 1'b1);
      chk("parity_96", rx_par[1], 1'b0);
    end
    if (rx_cyc.size() >= 2) chk("parity_period", rx_cyc[1] - rx_cyc[0], FRAME + 1);
    check_frames();
    wait_idle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
